// File: rtl/display_alert_arbiter_pkg.sv
// ============================================================================
// Module : display_alert_arbiter_pkg
// Shared types and constants for the display alert arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package display_alert_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_FOLLOW    = 2'd0,
    ST_ALERT_TMR = 2'd1,
    ST_ALERT_ALM = 2'd2
  } state_e;

  localparam logic [3:0] MODE_OFF       = 4'b0001;
  localparam logic [3:0] MODE_CLOCK     = 4'b0010;
  localparam logic [3:0] MODE_STOPWATCH = 4'b0100;
  localparam logic [3:0] MODE_TIMER     = 4'b1000;

  localparam logic [1:0] SRC_NONE  = 2'd0;
  localparam logic [1:0] SRC_TIMER = 2'd1;
  localparam logic [1:0] SRC_ALARM = 2'd2;

  // Anything other than exactly one set bit parks the display on "off".
  function automatic logic [3:0] sanitize_mode(input logic [3:0] mode);
    if ((mode != 4'd0) && ((mode & (mode - 4'd1)) == 4'd0)) return mode;
    return MODE_OFF;
  endfunction

endpackage

`default_nettype wire

// File: rtl/display_alert_arbiter_alert_tick_gen.sv
// ============================================================================
// Module : alert_tick_gen
// Cycle prescaler with sync clear: half-blink tick and, with ALERT_TIMEOUT_EN,
// a one-second tick.  Rev : 1.0
// ============================================================================
`default_nettype none

module alert_tick_gen
  import display_alert_arbiter_pkg::*;
#(
  parameter int unsigned HALF_CYC = 10,
  parameter int unsigned SEC_CYC  = 100
) (
  input  logic clk_i,
  input  logic nreset_i,
  input  logic clr_i,
  output logic half_tick_o,
  output logic sec_tick_o
);

  localparam int unsigned HALF_W = (HALF_CYC > 1) ? $clog2(HALF_CYC) : 1;

  logic [HALF_W-1:0] half_cnt_q;

  // Ticks are raw counter decodes so the caller can fold them into clear logic.
  assign half_tick_o = (half_cnt_q == HALF_W'(HALF_CYC - 1));

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i)                  half_cnt_q <= '0;
    else if (clr_i || half_tick_o)  half_cnt_q <= '0;
    else                            half_cnt_q <= half_cnt_q + 1'b1;
  end

`ifdef ALERT_TIMEOUT_EN
  localparam int unsigned SEC_W = (SEC_CYC > 1) ? $clog2(SEC_CYC) : 1;

  logic [SEC_W-1:0] sec_cnt_q;

  assign sec_tick_o = (sec_cnt_q == SEC_W'(SEC_CYC - 1));

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i)                 sec_cnt_q <= '0;
    else if (clr_i || sec_tick_o)  sec_cnt_q <= '0;
    else                           sec_cnt_q <= sec_cnt_q + 1'b1;
  end
`else
  logic unused_sec_w;
  assign unused_sec_w = ^SEC_CYC;
  assign sec_tick_o   = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/display_alert_arbiter.sv
// ============================================================================
// Module : display_alert_arbiter
// Hands the 7-segment display to the user mode or to a flashing alert; optional
// auto-timeout compiled in with ALERT_TIMEOUT_EN.  Rev : 1.0
// ============================================================================
`default_nettype none

module display_alert_arbiter
  import display_alert_arbiter_pkg::*;
#(
  parameter int unsigned CLK_HZ        = 50_000_000,
  parameter int unsigned BLINK_HALF_MS = 250,
  parameter int unsigned ALERT_SEC     = 10
) (
  input  logic       clk_i,
  input  logic       nreset_i,
  input  logic [3:0] user_mode_i,
  input  logic       timer_done_i,
  input  logic       alarm_match_i,
  input  logic       ack_i,
  output logic [3:0] grant_o,
  output logic       alert_o,
  output logic [1:0] alert_src_o,
  output logic       flash_o,
  output logic       ack_consumed_o
);

  localparam int unsigned HALF_CYC =
    32'((64'(CLK_HZ) * 64'(BLINK_HALF_MS)) / 64'd1000);

  state_e     state_q, state_d;
  logic       pend_tmr_q, pend_tmr_d;
  logic       pend_alm_q, pend_alm_d;
  logic [3:0] grant_q, grant_d;
  logic       alert_q, alert_d;
  logic [1:0] src_q, src_d;
  logic       flash_q, flash_d;
  logic       ack_q, ack_d;
  logic       restart_w, clr_w, end_w, timeout_w;
  logic       half_tick_w, sec_tick_w;

  assign clr_w = restart_w || (state_d == ST_FOLLOW);

  alert_tick_gen #(
    .HALF_CYC (HALF_CYC),
    .SEC_CYC  (CLK_HZ)
  ) u_tick_gen (
    .clk_i       (clk_i),
    .nreset_i    (nreset_i),
    .clr_i       (clr_w),
    .half_tick_o (half_tick_w),
    .sec_tick_o  (sec_tick_w)
  );

`ifdef ALERT_TIMEOUT_EN
  localparam int unsigned SEC_W = (ALERT_SEC > 1) ? $clog2(ALERT_SEC) : 1;

  logic [SEC_W-1:0] secs_q;

  assign timeout_w = (state_q != ST_FOLLOW) && sec_tick_w &&
                     (secs_q == SEC_W'(ALERT_SEC - 1));

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i)       secs_q <= '0;
    else if (clr_w)      secs_q <= '0;
    else if (sec_tick_w) secs_q <= secs_q + 1'b1;
  end
`else
  logic unused_timeout_w;
  assign unused_timeout_w = sec_tick_w ^ (^ALERT_SEC);
  assign timeout_w        = 1'b0;
`endif

  assign end_w = ack_i || timeout_w;

  // An ending alert is resolved before same-cycle events: other-source events
  // become pending (and are entered at once), same-source events are dropped.
  always_comb begin
    state_d    = state_q;
    pend_tmr_d = pend_tmr_q;
    pend_alm_d = pend_alm_q;
    ack_d      = 1'b0;
    restart_w  = 1'b0;
    case (state_q)
      ST_FOLLOW: begin
        if (timer_done_i) begin
          state_d   = ST_ALERT_TMR;
          restart_w = 1'b1;
          if (alarm_match_i) pend_alm_d = 1'b1;
        end else if (alarm_match_i) begin
          state_d   = ST_ALERT_ALM;
          restart_w = 1'b1;
        end
      end
      ST_ALERT_TMR: begin
        ack_d = ack_i;
        if (alarm_match_i) pend_alm_d = 1'b1;
        if (end_w) begin
          if (pend_alm_d) begin
            state_d    = ST_ALERT_ALM;
            pend_alm_d = 1'b0;
            restart_w  = 1'b1;
          end else begin
            state_d = ST_FOLLOW;
          end
        end else if (timer_done_i) begin
          restart_w = 1'b1;
        end
      end
      ST_ALERT_ALM: begin
        ack_d = ack_i;
        if (timer_done_i) pend_tmr_d = 1'b1;
        if (end_w) begin
          if (pend_tmr_d) begin
            state_d    = ST_ALERT_TMR;
            pend_tmr_d = 1'b0;
            restart_w  = 1'b1;
          end else begin
            state_d = ST_FOLLOW;
          end
        end else if (alarm_match_i) begin
          restart_w = 1'b1;
        end
      end
      default: state_d = ST_FOLLOW;
    endcase
  end

  always_comb begin
    grant_d = sanitize_mode(user_mode_i);
    alert_d = 1'b0;
    src_d   = SRC_NONE;
    flash_d = 1'b1;
    if (state_d != ST_FOLLOW) begin
      alert_d = 1'b1;
      flash_d = restart_w ? 1'b1 : (half_tick_w ? ~flash_q : flash_q);
      if (state_d == ST_ALERT_TMR) begin
        grant_d = MODE_TIMER;
        src_d   = SRC_TIMER;
      end else begin
        grant_d = MODE_CLOCK;
        src_d   = SRC_ALARM;
      end
    end
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_q    <= ST_FOLLOW;
      pend_tmr_q <= 1'b0;
      pend_alm_q <= 1'b0;
      grant_q    <= MODE_OFF;
      alert_q    <= 1'b0;
      src_q      <= SRC_NONE;
      flash_q    <= 1'b1;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_tmr_q <= pend_tmr_d;
      pend_alm_q <= pend_alm_d;
      grant_q    <= grant_d;
      alert_q    <= alert_d;
      src_q      <= src_d;
      flash_q    <= flash_d;
      ack_q      <= ack_d;
    end
  end

  assign grant_o        = grant_q;
  assign alert_o        = alert_q;
  assign alert_src_o    = src_q;
  assign flash_o        = flash_q;
  assign ack_consumed_o = ack_q;

endmodule

`default_nettype wire

// File: tb/tb_display_alert_arbiter.sv
// ============================================================================
// Module : tb_display_alert_arbiter
// Directed stimulus with a cycle-stamped expectation queue and monitor.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_display_alert_arbiter;

  logic       clk = 1'b0;
  logic       nreset = 1'b0;
  logic [3:0] user_mode = 4'b0001;
  logic       timer_done = 1'b0;
  logic       alarm_match = 1'b0;
  logic       ack = 1'b0;
  logic [3:0] grant;
  logic       alert;
  logic [1:0] src;
  logic       flash;
  logic       ack_cons;

  display_alert_arbiter #(
    .CLK_HZ        (100),
    .BLINK_HALF_MS (100),
    .ALERT_SEC     (3)
  ) dut (
    .clk_i          (clk),
    .nreset_i       (nreset),
    .user_mode_i    (user_mode),
    .timer_done_i   (timer_done),
    .alarm_match_i  (alarm_match),
    .ack_i          (ack),
    .grant_o        (grant),
    .alert_o        (alert),
    .alert_src_o    (src),
    .flash_o        (flash),
    .ack_consumed_o (ack_cons)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    string      name;
    logic [3:0] grant;
    logic       alert;
    logic [1:0] src;
    logic       flash;
    logic       ack;
  } exp_t;

  exp_t sb[$];
  int n_pass = 0;
  int n_total = 0;
  int n_to = 0;
  int n_left = 0;

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      n_total++;
      if (e.cyc != cyc || grant !== e.grant || alert !== e.alert ||
          src !== e.src || flash !== e.flash || ack_cons !== e.ack)
        $display("FAIL %s cyc=%0d(exp %0d): got grant=%b alert=%b src=%0d flash=%b ack=%b, required grant=%b alert=%b src=%0d flash=%b ack=%b",
                 e.name, cyc, e.cyc, grant, alert, src, flash, ack_cons,
                 e.grant, e.alert, e.src, e.flash, e.ack);
      else
        n_pass++;
    end
  end

  task automatic push(input int c, input string nm, input logic [3:0] g,
                      input logic a, input logic [1:0] s, input logic f,
                      input logic k);
    exp_t e;
    e = '{cyc: c, name: nm, grant: g, alert: a, src: s, flash: f, ack: k};
    sb.push_back(e);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_until(input int c);
    int guard = 0;
    while (cyc < c && guard < 5000) begin
      step();
      guard++;
    end
    if (cyc != c) begin
      n_to++;
      $display("FAIL wait_until: reached cyc=%0d, required %0d", cyc, c);
    end
  endtask

  int e0;

  initial begin
    // reset values
    step();
    push(cyc + 1, "reset", 4'b0001, 1'b0, 2'd0, 1'b1, 1'b0);
    step();
    step();
    nreset = 1'b1;

    // follow mode: one-hot passes, multi-hot parks on off
    step(); user_mode = 4'b0100; push(cyc + 1, "mode_sw",  4'b0100, 0, 2'd0, 1, 0);
    step(); user_mode = 4'b0110; push(cyc + 1, "mode_bad", 4'b0001, 0, 2'd0, 1, 0);
    step(); user_mode = 4'b0000; push(cyc + 1, "mode_zero", 4'b0001, 0, 2'd0, 1, 0);
    step(); user_mode = 4'b0010; push(cyc + 1, "mode_clk", 4'b0010, 0, 2'd0, 1, 0);
    step();

    // timer alert, flash phase, ack
    step(); timer_done = 1'b1; e0 = cyc + 1;
    push(e0,      "tmr_entry", 4'b1000, 1, 2'd1, 1, 0);
    push(e0 + 9,  "flash_9",   4'b1000, 1, 2'd1, 1, 0);
    push(e0 + 10, "flash_10",  4'b1000, 1, 2'd1, 0, 0);
    push(e0 + 19, "flash_19",  4'b1000, 1, 2'd1, 0, 0);
    push(e0 + 20, "flash_20",  4'b1000, 1, 2'd1, 1, 0);
    step(); timer_done = 1'b0;
    wait_until(e0 + 24);
    ack = 1'b1;
    push(e0 + 25, "tmr_ack",   4'b0010, 0, 2'd0, 1, 1);
    push(e0 + 26, "ack_pulse", 4'b0010, 0, 2'd0, 1, 0);
    step(); ack = 1'b0;
    step(); step();

    // simultaneous events: timer first, alarm pending
    step(); timer_done = 1'b1; alarm_match = 1'b1; e0 = cyc + 1;
    push(e0, "both_tmr", 4'b1000, 1, 2'd1, 1, 0);
    step(); timer_done = 1'b0; alarm_match = 1'b0;
    wait_until(e0 + 3);
    ack = 1'b1;
    push(e0 + 4, "pend_alm", 4'b0010, 1, 2'd2, 1, 1);
    step(); ack = 1'b0;
    wait_until(e0 + 6);
    ack = 1'b1;
    push(e0 + 7, "alm_ack", 4'b0010, 0, 2'd0, 1, 1);
    step(); ack = 1'b0;
    step();

    // ack together with same-source event: alert ends, no re-entry
    step(); timer_done = 1'b1; e0 = cyc + 1;
    push(e0, "tmr2_entry", 4'b1000, 1, 2'd1, 1, 0);
    step(); timer_done = 1'b0;
    wait_until(e0 + 2);
    ack = 1'b1; timer_done = 1'b1;
    push(e0 + 3, "ack_same",  4'b0010, 0, 2'd0, 1, 1);
    push(e0 + 4, "no_reentr", 4'b0010, 0, 2'd0, 1, 0);
    step(); ack = 1'b0; timer_done = 1'b0;
    step();

    // ack in follow mode is not consumed
    step(); ack = 1'b1;
    push(cyc + 1, "ack_follow", 4'b0010, 0, 2'd0, 1, 0);
    step(); ack = 1'b0;
    step();

`ifdef ALERT_TIMEOUT_EN
    step(); alarm_match = 1'b1; e0 = cyc + 1;
    push(e0,       "alm_entry", 4'b0010, 1, 2'd2, 1, 0);
    push(e0 + 299, "to_299",    4'b0010, 1, 2'd2, 0, 0);
    push(e0 + 300, "to_300",    4'b0010, 0, 2'd0, 1, 0);
    step(); alarm_match = 1'b0;
    wait_until(e0 + 305);

    step(); alarm_match = 1'b1; e0 = cyc + 1;
    push(e0,       "alm2_entry", 4'b0010, 1, 2'd2, 1, 0);
    push(e0 + 149, "alm2_149",   4'b0010, 1, 2'd2, 1, 0);
    step(); alarm_match = 1'b0;
    wait_until(e0 + 149);
    alarm_match = 1'b1;
    push(e0 + 150, "restart",    4'b0010, 1, 2'd2, 1, 0);
    push(e0 + 449, "rto_449",    4'b0010, 1, 2'd2, 0, 0);
    push(e0 + 450, "rto_450",    4'b0010, 0, 2'd0, 1, 0);
    step(); alarm_match = 1'b0;
    wait_until(e0 + 455);
`else
    step(); alarm_match = 1'b1; e0 = cyc + 1;
    push(e0,        "alm_entry", 4'b0010, 1, 2'd2, 1, 0);
    push(e0 + 1000, "held_1000", 4'b0010, 1, 2'd2, 1, 0);
    step(); alarm_match = 1'b0;
    wait_until(e0 + 1000);
    ack = 1'b1;
    push(e0 + 1001, "held_ack",  4'b0010, 0, 2'd0, 1, 1);
    step(); ack = 1'b0;
    step();
`endif

    // reset mid-alert with alarm pending
    step(); timer_done = 1'b1; alarm_match = 1'b1; e0 = cyc + 1;
    push(e0, "rst_pre", 4'b1000, 1, 2'd1, 1, 0);
    step(); timer_done = 1'b0; alarm_match = 1'b0;
    step(); nreset = 1'b0;
    push(e0 + 2, "rst_mid", 4'b0001, 0, 2'd0, 1, 0);
    step(); step(); nreset = 1'b1;
    push(e0 + 4,  "rst_rel",  4'b0010, 0, 2'd0, 1, 0);
    push(e0 + 20, "rst_nopend", 4'b0010, 0, 2'd0, 1, 0);
    wait_until(e0 + 22);

    step(); step();
    n_left = sb.size();
    if (n_left != 0)
      $display("FAIL scoreboard: %0d expectations never checked, required 0", n_left);
    $display("%0d/%0d checks passed", n_pass, n_total + n_to + n_left);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/display_alert_arbiter.md
# display_alert_arbiter

Arbitrates ownership of the shared 8-digit 7-segment display path between user-selected mode (off/clock/stopwatch/timer) and asynchronous alert events (timer expiry, alarm match). Sits between the three-phase mode selector and the display mux/blink gating: alerts preempt the user selection, flash the display, and end on acknowledge or timeout. Pending alerts are queued so none is lost.

## Interface
- CLK_HZ, 50_000_000, clk_i frequency in Hz
- BLINK_HALF_MS, 250, flash half-period in ms; half-period in cycles = CLK_HZ*BLINK_HALF_MS/1000
- ALERT_SEC, 10, alert auto-timeout in seconds (used only with ALERT_TIMEOUT_EN)

- clk_i  in  1  system clock, single clock domain
- nreset_i  in  1  asynchronous, active-low reset
- user_mode_i  in  4  one-hot {timer, stopwatch, clock, off} from mode selector
- timer_done_i  in  1  one-cycle pulse, timer reached zero
- alarm_match_i  in  1  one-cycle pulse, clock equals alarm time
- ack_i  in  1  one-cycle debounced key press pulse
- grant_o  out  4  one-hot display owner {timer, stopwatch, clock, off}
- alert_o  out  1  high while an alert is being served
- alert_src_o  out  2  0 none, 1 timer, 2 alarm
- flash_o  out  1  display enable; toggles during alert, 1 otherwise
- ack_consumed_o  out  1  one-cycle pulse: ack_i absorbed by arbiter

## Operation
- States: FOLLOW, ALERT_TMR, ALERT_ALM.
- FOLLOW: grant_o = registered user_mode_i; non-one-hot input (0 or >1 bit) -> grant off (4'b0001). alert_o=0, alert_src_o=0, flash_o=1.
- ALERT_TMR: grant timer, alert_src_o=1. ALERT_ALM: grant clock, alert_src_o=2. alert_o=1 in both.
- Event in FOLLOW: timer_done_i -> ALERT_TMR; alarm_match_i -> ALERT_ALM; both same cycle -> ALERT_TMR, alarm latched pending.
- Event for the other source during an alert: set that source's pending flag (one bit each; repeats collapse).
- Event for the source being served: restart timeout and flash phase; no pending set.
- Alert end (ack or timeout): if other source pending -> enter it, clear its flag; else -> FOLLOW.
- ack_i in alert: ends alert, ack_consumed_o pulses. ack_i in FOLLOW: ignored, no pulse (key retains normal function downstream).
- ack_i and new event same cycle: ack ends current alert first, then event is treated as pending/entered per rules above (same-source event with ack -> alert ends, no re-entry).
- Flash: on alert entry flash_o=1, phase counter cleared; toggles every half-period cycles.

## Timing
- Reset: state FOLLOW, grant_o=4'b0001, alert_o=0, alert_src_o=0, flash_o=1, ack_consumed_o=0, pending flags and counters 0.
- All outputs registered. user_mode_i change at cycle N -> grant_o at N+1.
- Event pulse at N -> alert_o/grant_o/alert_src_o at N+1.
- ack_i at N -> ack_consumed_o high exactly cycle N+1, new state visible N+1.
- First flash toggle exactly half-period cycles after alert entry.
- Timeout: alert ends exactly ALERT_SEC*CLK_HZ cycles after entry/restart.
- Reset asserted mid-alert: immediate return to reset values; pending lost.

## Configuration
- ALERT_TIMEOUT_EN defined: seconds counter active, alert auto-ends after ALERT_SEC seconds.
- Undefined: no timeout counter compiled; alert held until ack_i; ALERT_SEC ignored.

## Structure
- Shared package: state enum, one-hot mode constants (MODE_OFF/CLOCK/STOPWATCH/TIMER), alert source codes.
- One sub-module: alert_tick_gen — cycle prescaler with sync clear, emits half-blink tick and (with ALERT_TIMEOUT_EN) one-second tick.

## Test plan
(CLK_HZ=100, BLINK_HALF_MS=100 -> 10-cycle half-period, ALERT_SEC=3 -> 300 cycles)
- user_mode_i=0100 then 0110 -> grant_o=0100 one cycle later, then 0001.
- timer_done_i pulse in clock mode -> next cycle grant_o=1000, alert_src_o=1; flash_o toggles at +10, +20; ack_i -> ack_consumed_o 1 cycle, grant_o back to 0010.
- timer_done_i and alarm_match_i same cycle -> ALERT_TMR; ack -> ALERT_ALM (grant 0010, src 2); ack -> FOLLOW.
- ALERT_TIMEOUT_EN on: alarm_match_i, no ack -> alert_o falls exactly 300 cycles after entry; second alarm at +150 -> falls at +450.
- ALERT_TIMEOUT_EN off: alarm alert held 1000 cycles with no ack; ack_i in FOLLOW -> no ack_consumed_o.
- nreset_i low during ALERT_TMR with alarm pending -> all outputs at reset values immediately, no alarm alert after release.
